// File: rtl/master_axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write master port between NUM_REQ local requesters.
// One transaction in flight at a time: address, data burst, then write response.
module master_axi_wr_arbiter #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned ID_WIDTH = 2,
  parameter int unsigned IDX_W    = 1
) (
  input  logic                         M_CLK,
  input  logic                         M_RSTN,
  input  logic [NUM_REQ*ID_WIDTH-1:0]  S_WR_ADDR_ID,
  input  logic [NUM_REQ*32-1:0]        S_WR_ADDR,
  input  logic [NUM_REQ*8-1:0]         S_WR_ADDR_LEN,
  input  logic [NUM_REQ*2-1:0]         S_WR_ADDR_BURST,
  input  logic [NUM_REQ-1:0]           S_WR_ADDR_VALID,
  output logic [NUM_REQ-1:0]           S_WR_ADDR_READY,
  input  logic [NUM_REQ*32-1:0]        S_WR_DATA,
  input  logic [NUM_REQ*4-1:0]         S_WR_STRB,
  input  logic [NUM_REQ-1:0]           S_WR_DATA_LAST,
  input  logic [NUM_REQ-1:0]           S_WR_DATA_VALID,
  output logic [NUM_REQ-1:0]           S_WR_DATA_READY,
  output logic [ID_WIDTH-1:0]          S_WR_BACK_ID,
  output logic [1:0]                   S_WR_BACK_RESP,
  output logic [NUM_REQ-1:0]           S_WR_BACK_VALID,
  input  logic [NUM_REQ-1:0]           S_WR_BACK_READY,
  output logic [ID_WIDTH-1:0]          M_WR_ADDR_ID,
  output logic [31:0]                  M_WR_ADDR,
  output logic [7:0]                   M_WR_ADDR_LEN,
  output logic [1:0]                   M_WR_ADDR_BURST,
  output logic                         M_WR_ADDR_VALID,
  input  logic                         M_WR_ADDR_READY,
  output logic [31:0]                  M_WR_DATA,
  output logic [3:0]                   M_WR_STRB,
  output logic                         M_WR_DATA_LAST,
  output logic                         M_WR_DATA_VALID,
  input  logic                         M_WR_DATA_READY,
  input  logic [ID_WIDTH-1:0]          M_WR_BACK_ID,
  input  logic [1:0]                   M_WR_BACK_RESP,
  input  logic                         M_WR_BACK_VALID,
  output logic                         M_WR_BACK_READY,
  output logic                         busy,
  output logic [IDX_W-1:0]             grant_idx
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned BRST_W = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic               busy_q, busy_d;
  logic               found;
  logic [IDX_W-1:0]   cand;
  logic               aw_hs, w_last_hs, b_hs;

  logic [ID_WIDTH-1:0] aw_id_arr    [NUM_REQ];
  logic [ADDR_W-1:0]   aw_addr_arr  [NUM_REQ];
  logic [LEN_W-1:0]    aw_len_arr   [NUM_REQ];
  logic [BRST_W-1:0]   aw_burst_arr [NUM_REQ];
  logic [DATA_W-1:0]   w_data_arr   [NUM_REQ];
  logic [STRB_W-1:0]   w_strb_arr   [NUM_REQ];

  // Unpack flat requester buses into per-requester slices
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign aw_id_arr[g]    = S_WR_ADDR_ID[g*ID_WIDTH +: ID_WIDTH];
    assign aw_addr_arr[g]  = S_WR_ADDR[g*ADDR_W +: ADDR_W];
    assign aw_len_arr[g]   = S_WR_ADDR_LEN[g*LEN_W +: LEN_W];
    assign aw_burst_arr[g] = S_WR_ADDR_BURST[g*BRST_W +: BRST_W];
    assign w_data_arr[g]   = S_WR_DATA[g*DATA_W +: DATA_W];
    assign w_strb_arr[g]   = S_WR_STRB[g*STRB_W +: STRB_W];
  end

  assign aw_hs     = (state_q == ADDR) && S_WR_ADDR_VALID[grant_q] && M_WR_ADDR_READY;
  assign w_last_hs = (state_q == DATA) && S_WR_DATA_VALID[grant_q] && M_WR_DATA_READY
                     && S_WR_DATA_LAST[grant_q];
  assign b_hs      = (state_q == RESP) && M_WR_BACK_VALID && S_WR_BACK_READY[grant_q];

  // Next-state, round-robin search and pointer update
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    found   = 1'b0;
    cand    = '0;
    case (state_q)
      IDLE: begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          cand = IDX_W'((32'(rr_q) + i) % NUM_REQ);
          if (!found && S_WR_ADDR_VALID[cand]) begin
            found   = 1'b1;
            grant_d = cand;
          end
        end
        if (found) state_d = ADDR;
      end
      ADDR: if (aw_hs) state_d = DATA;
      DATA: if (w_last_hs) state_d = RESP;
      RESP: begin
        if (b_hs) begin
          rr_d    = IDX_W'((32'(grant_q) + 32'd1) % NUM_REQ);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge M_CLK or negedge M_RSTN) begin
    if (!M_RSTN) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      busy_q  <= busy_d;
    end
  end

  // Channel steering: payloads always follow grant, handshakes only in their phase
  always_comb begin
    M_WR_ADDR_ID    = aw_id_arr[grant_q];
    M_WR_ADDR       = aw_addr_arr[grant_q];
    M_WR_ADDR_LEN   = aw_len_arr[grant_q];
    M_WR_ADDR_BURST = aw_burst_arr[grant_q];
    M_WR_DATA       = w_data_arr[grant_q];
    M_WR_STRB       = w_strb_arr[grant_q];
    M_WR_DATA_LAST  = S_WR_DATA_LAST[grant_q];
    S_WR_BACK_ID    = M_WR_BACK_ID;
    S_WR_BACK_RESP  = M_WR_BACK_RESP;
    M_WR_ADDR_VALID = 1'b0;
    M_WR_DATA_VALID = 1'b0;
    M_WR_BACK_READY = 1'b0;
    S_WR_ADDR_READY = '0;
    S_WR_DATA_READY = '0;
    S_WR_BACK_VALID = '0;
    case (state_q)
      ADDR: begin
        M_WR_ADDR_VALID          = S_WR_ADDR_VALID[grant_q];
        S_WR_ADDR_READY[grant_q] = M_WR_ADDR_READY;
      end
      DATA: begin
        M_WR_DATA_VALID          = S_WR_DATA_VALID[grant_q];
        S_WR_DATA_READY[grant_q] = M_WR_DATA_READY;
      end
      RESP: begin
        M_WR_BACK_READY          = S_WR_BACK_READY[grant_q];
        S_WR_BACK_VALID[grant_q] = M_WR_BACK_VALID;
      end
      default: ;
    endcase
  end

  assign busy      = busy_q;
  assign grant_idx = grant_q;

endmodule

// File: tb/tb_master_axi_wr_arbiter.sv
// Randomized bench for master_axi_wr_arbiter against a transaction-level round-robin model.
module tb_master_axi_wr_arbiter;

  localparam int N  = 2;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*IW-1:0] s_awid;
  logic [N*32-1:0] s_awaddr;
  logic [N*8-1:0]  s_awlen;
  logic [N*2-1:0]  s_awburst;
  logic [N-1:0]    s_awvalid, s_awready;
  logic [N*32-1:0] s_wdata;
  logic [N*4-1:0]  s_wstrb;
  logic [N-1:0]    s_wlast, s_wvalid, s_wready;
  logic [IW-1:0]   s_bid;
  logic [1:0]      s_bresp;
  logic [N-1:0]    s_bvalid, s_bready;
  logic [IW-1:0]   m_awid;
  logic [31:0]     m_awaddr;
  logic [7:0]      m_awlen;
  logic [1:0]      m_awburst;
  logic            m_awvalid, m_awready;
  logic [31:0]     m_wdata;
  logic [3:0]      m_wstrb;
  logic            m_wlast, m_wvalid, m_wready;
  logic [IW-1:0]   m_bid;
  logic [1:0]      m_bresp;
  logic            m_bvalid, m_bready;
  logic            busy;
  logic [0:0]      grant_idx;

  // Per-requester stimulus and model state
  logic [IW-1:0] r_id    [N];
  logic [31:0]   r_addr  [N];
  logic [7:0]    r_len   [N];
  logic [1:0]    r_burst [N];
  logic [31:0]   r_wdata [N];
  logic [3:0]    r_wstrb [N];
  logic [31:0]   beat_d  [N][16];
  logic [3:0]    beat_s  [N][16];
  bit            pend    [N];
  int            rr;
  int            n_checks = 0;
  int            n_errors = 0;

  always_comb begin
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awburst = '0; s_wdata = '0; s_wstrb = '0;
    for (int r = 0; r < N; r++) begin
      s_awid[r*IW +: IW]  = r_id[r];
      s_awaddr[r*32 +: 32] = r_addr[r];
      s_awlen[r*8 +: 8]    = r_len[r];
      s_awburst[r*2 +: 2]  = r_burst[r];
      s_wdata[r*32 +: 32]  = r_wdata[r];
      s_wstrb[r*4 +: 4]    = r_wstrb[r];
    end
  end

  master_axi_wr_arbiter #(.NUM_REQ(N), .ID_WIDTH(IW), .IDX_W(1)) dut (
    .M_CLK(clk), .M_RSTN(rst_n),
    .S_WR_ADDR_ID(s_awid), .S_WR_ADDR(s_awaddr), .S_WR_ADDR_LEN(s_awlen),
    .S_WR_ADDR_BURST(s_awburst), .S_WR_ADDR_VALID(s_awvalid), .S_WR_ADDR_READY(s_awready),
    .S_WR_DATA(s_wdata), .S_WR_STRB(s_wstrb), .S_WR_DATA_LAST(s_wlast),
    .S_WR_DATA_VALID(s_wvalid), .S_WR_DATA_READY(s_wready),
    .S_WR_BACK_ID(s_bid), .S_WR_BACK_RESP(s_bresp), .S_WR_BACK_VALID(s_bvalid),
    .S_WR_BACK_READY(s_bready),
    .M_WR_ADDR_ID(m_awid), .M_WR_ADDR(m_awaddr), .M_WR_ADDR_LEN(m_awlen),
    .M_WR_ADDR_BURST(m_awburst), .M_WR_ADDR_VALID(m_awvalid), .M_WR_ADDR_READY(m_awready),
    .M_WR_DATA(m_wdata), .M_WR_STRB(m_wstrb), .M_WR_DATA_LAST(m_wlast),
    .M_WR_DATA_VALID(m_wvalid), .M_WR_DATA_READY(m_wready),
    .M_WR_BACK_ID(m_bid), .M_WR_BACK_RESP(m_bresp), .M_WR_BACK_VALID(m_bvalid),
    .M_WR_BACK_READY(m_bready),
    .busy(busy), .grant_idx(grant_idx)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first pending requester at or after rr, modulo N
  function automatic int pick();
    for (int i = 0; i < N; i++)
      if (pend[(rr + i) % N]) return (rr + i) % N;
    return -1;
  endfunction

  task automatic new_req(input int r, input int flen);
    pend[r]    = 1'b1;
    r_id[r]    = IW'($urandom);
    r_addr[r]  = $urandom;
    r_len[r]   = (flen < 0) ? 8'($urandom_range(0, 15)) : 8'(flen);
    r_burst[r] = 2'($urandom);
    for (int b = 0; b < 16; b++) begin
      beat_d[r][b] = $urandom;
      beat_s[r][b] = 4'($urandom);
    end
    s_awvalid[r] = 1'b1;
  endtask

  // Non-granted requesters may present early data; it must never be accepted
  task automatic noise(input int skip);
    for (int r = 0; r < N; r++) begin
      if (r == skip) continue;
      s_wvalid[r] = pend[r] ? 1'($urandom_range(0, 1)) : 1'b0;
      s_wlast[r]  = (r_len[r] == 8'd0);
      r_wdata[r]  = beat_d[r][0];
      r_wstrb[r]  = beat_s[r][0];
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 0);
    check("rst_grant", 64'(grant_idx), 0);
    check("rst_awvalid", 64'(m_awvalid), 0);
    check("rst_awready", 64'(s_awready), 0);
    check("rst_wvalid", 64'(m_wvalid), 0);
    check("rst_wready", 64'(s_wready), 0);
    check("rst_bvalid", 64'(s_bvalid), 0);
    check("rst_bready", 64'(m_bready), 0);
    s_awvalid = '0; s_wvalid = '0; s_wlast = '0; s_bready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    for (int r = 0; r < N; r++) pend[r] = 1'b0;
    rr = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic run_txn(input logic [N-1:0] add, input bit rnd, input int flen, input int abort_at);
    int w, beat, cyc;
    bit hs, sv, mr;
    logic [IW-1:0] rid;
    logic [1:0] rresp;
    for (int r = 0; r < N; r++)
      if (!pend[r] && (add[r] || (rnd && $urandom_range(0, 1) == 1))) new_req(r, flen);
    if (rnd && pick() < 0) new_req(int'($urandom_range(0, N - 1)), flen);
    w = pick();
    if (w < 0) return;
    noise(N);
    m_bvalid = 1'($urandom_range(0, 1));
    s_bready = N'($urandom);
    #1;
    check("idle_busy", 64'(busy), 0);
    check("idle_awvalid", 64'(m_awvalid), 0);
    check("idle_awready", 64'(s_awready), 0);
    check("idle_bready", 64'(m_bready), 0);
    check("idle_bvalid", 64'(s_bvalid), 0);
    step();
    check("grant", 64'(grant_idx), 64'(w));
    check("grant_busy", 64'(busy), 1);
    // address phase
    cyc = 0;
    do begin
      m_awready = (cyc >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
      noise(N);
      m_bvalid = 1'($urandom_range(0, 1));
      s_bready = N'($urandom);
      #1;
      check("aw_valid", 64'(m_awvalid), 1);
      check("aw_id", 64'(m_awid), 64'(r_id[w]));
      check("aw_addr", 64'(m_awaddr), 64'(r_addr[w]));
      check("aw_len", 64'(m_awlen), 64'(r_len[w]));
      check("aw_burst", 64'(m_awburst), 64'(r_burst[w]));
      check("aw_sready", 64'(s_awready), 64'({N{m_awready}} & (N'(1) << w)));
      check("aw_early_wready", 64'(s_wready), 0);
      check("aw_wvalid", 64'(m_wvalid), 0);
      check("aw_bready", 64'(m_bready), 0);
      hs = m_awready;
      cyc++;
      step();
    end while (!hs);
    s_awvalid[w] = 1'b0;
    pend[w] = 1'b0;
    m_awready = 1'b0;
    // data phase
    beat = 0;
    cyc = 0;
    while (beat <= int'(r_len[w])) begin
      sv = (cyc >= 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
      mr = (cyc >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
      s_wvalid[w] = sv;
      m_wready    = mr;
      r_wdata[w]  = beat_d[w][beat];
      r_wstrb[w]  = beat_s[w][beat];
      s_wlast[w]  = (beat == int'(r_len[w]));
      noise(w);
      m_bvalid = 1'($urandom_range(0, 1));
      s_bready = N'($urandom);
      #1;
      check("w_valid", 64'(m_wvalid), 64'(sv));
      check("w_data", 64'(m_wdata), 64'(beat_d[w][beat]));
      check("w_strb", 64'(m_wstrb), 64'(beat_s[w][beat]));
      check("w_last", 64'(m_wlast), 64'(beat == int'(r_len[w])));
      check("w_sready", 64'(s_wready), 64'({N{mr}} & (N'(1) << w)));
      check("w_awvalid", 64'(m_awvalid), 0);
      check("w_bready", 64'(m_bready), 0);
      check("w_bvalid", 64'(s_bvalid), 0);
      step();
      cyc++;
      if (sv && mr) begin
        beat++;
        cyc = 0;
        if (beat == abort_at) begin
          do_reset();
          return;
        end
      end
    end
    s_wvalid[w] = 1'b0;
    s_wlast[w]  = 1'b0;
    m_wready    = 1'b0;
    // response phase
    rid   = IW'($urandom);
    rresp = 2'($urandom);
    cyc = 0;
    do begin
      sv = (cyc >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
      mr = (cyc >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
      m_bvalid = sv;
      m_bid    = rid;
      m_bresp  = rresp;
      s_bready = N'($urandom);
      s_bready[w] = mr;
      noise(w);
      #1;
      check("b_svalid", 64'(s_bvalid), 64'({N{sv}} & (N'(1) << w)));
      check("b_mready", 64'(m_bready), 64'(mr));
      check("b_id", 64'(s_bid), 64'(rid));
      check("b_resp", 64'(s_bresp), 64'(rresp));
      check("b_busy", 64'(busy), 1);
      check("b_awvalid", 64'(m_awvalid), 0);
      check("b_wvalid", 64'(m_wvalid), 0);
      hs = sv && mr;
      cyc++;
      step();
    end while (!hs);
    m_bvalid = 1'b0;
    s_bready = '0;
    rr = (w + 1) % N;
    check("post_busy", 64'(busy), 0);
  endtask

  function automatic bit any_pend();
    for (int r = 0; r < N; r++) if (pend[r]) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    s_awvalid = '0; s_wvalid = '0; s_wlast = '0; s_bready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bid = '0; m_bresp = '0;
    for (int r = 0; r < N; r++) begin
      r_id[r] = '0; r_addr[r] = '0; r_len[r] = '0; r_burst[r] = '0;
      r_wdata[r] = '0; r_wstrb[r] = '0; pend[r] = 1'b0;
    end
    rr = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 0);
    check("reset_grant", 64'(grant_idx), 0);
    check("reset_awvalid", 64'(m_awvalid), 0);
    check("reset_ready", 64'({s_awready, s_wready, m_bready}), 0);
    check("reset_valid", 64'({m_wvalid, s_bvalid}), 0);
    rst_n = 1'b1;
    step();
    // contention straight out of reset: req0 then req1
    run_txn(2'b11, 1'b0, 3, -1);
    run_txn(2'b00, 1'b0, -1, -1);
    // both requesters continuously valid
    for (int t = 0; t < 6; t++) run_txn(2'b11, 1'b0, -1, -1);
    for (int t = 0; t < 40; t++) run_txn(2'b00, 1'b1, -1, -1);
    while (any_pend()) run_txn(2'b00, 1'b0, -1, -1);
    // leave rr at 1, then reset mid-burst and confirm rr returns to 0
    run_txn(2'b01, 1'b0, 3, -1);
    run_txn(2'b10, 1'b0, 3, 2);
    run_txn(2'b11, 1'b0, -1, -1);
    while (any_pend()) run_txn(2'b00, 1'b0, -1, -1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
